// File: rtl/view_angles_extract_pkg.sv
// view_pkg: Q16.16 widths, CORDIC arctangent table and gain, FSM states and angle helpers
package view_pkg;
  localparam int W = 32;
  localparam int FRAC = 16;
  localparam int DW = 36;
  localparam int AW = 32;
  localparam int ITERS = 16;
  localparam logic signed [W-1:0] CLAMP = 32'sd131072;
  localparam logic signed [AW-1:0] DEG90 = 32'sd5898240;
  localparam logic signed [AW-1:0] DEG360 = 32'sd23592960;
  localparam logic signed [17:0] INV_K = 18'sd39797;
  localparam logic signed [AW-1:0] ATAN [ITERS] = '{
    32'sd2949120, 32'sd1740967, 32'sd919879, 32'sd466945,
    32'sd234379,  32'sd117304,  32'sd58666,  32'sd29335,
    32'sd14668,   32'sd7334,    32'sd3667,   32'sd1833,
    32'sd917,     32'sd458,     32'sd229,    32'sd115
  };
  typedef enum logic [2:0] {IDLE, YAW, PITCH, ROLL, DONE} state_t;
  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] v);
    return v > CLAMP ? CLAMP : v < -CLAMP ? -CLAMP : v;
  endfunction
  function automatic logic [8:0] deg_int(input logic signed [AW-1:0] z);
    logic signed [AW-1:0] a;
    logic [15:0] r;
    a = z < 0 ? z + DEG360 : z;
`ifdef VIEW_ANGLES_FRAC_EN
    r = 16'(a >>> FRAC);
`else
    r = 16'((a + 32'sd32768) >>> FRAC);
`endif
    return r >= 16'd360 ? 9'd0 : r[8:0];
  endfunction
`ifdef VIEW_ANGLES_FRAC_EN
  function automatic logic [3:0] deg_frac(input logic signed [AW-1:0] z);
    return 4'((z < 0 ? z + DEG360 : z) >>> (FRAC - 4));
  endfunction
`endif
endpackage

// File: rtl/view_angles_extract_cordic.sv
// cordic_vectoring: one vectoring iteration driving y toward zero while accumulating angle
module cordic_vectoring
  import view_pkg::*;
(
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [AW-1:0] z,
  input  logic [3:0]           shift,
  output logic signed [DW-1:0] x_n,
  output logic signed [DW-1:0] y_n,
  output logic signed [AW-1:0] z_n
);
  always_comb begin
    x_n = y[DW-1] ? x - (y >>> shift) : x + (y >>> shift);
    y_n = y[DW-1] ? y + (x >>> shift) : y - (x >>> shift);
    z_n = y[DW-1] ? z - ATAN[shift] : z + ATAN[shift];
  end
endmodule

// File: rtl/view_angles_extract.sv
// view_angles_extract: basis vectors to pitch/roll/yaw via one shared CORDIC; VIEW_ANGLES_FRAC_EN adds 1/16-degree outputs
module view_angles_extract
  import view_pkg::*;
(
  input  logic                clk_100mhz,
  input  logic                rst_in,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic signed [W-1:0] x_forward,
  input  logic signed [W-1:0] y_forward,
  input  logic signed [W-1:0] z_forward,
  input  logic signed [W-1:0] x_up,
  input  logic signed [W-1:0] y_up,
  input  logic signed [W-1:0] z_up,
  input  logic signed [W-1:0] x_right,
  input  logic signed [W-1:0] y_right,
  input  logic signed [W-1:0] z_right,
  output logic [8:0]          pitch,
  output logic [8:0]          roll,
  output logic [8:0]          yaw,
`ifdef VIEW_ANGLES_FRAC_EN
  output logic [3:0]          pitch_frac,
  output logic [3:0]          roll_frac,
  output logic [3:0]          yaw_frac,
`endif
  output logic                valid_out
);
  state_t state, state_n;
  logic [4:0] cnt;
  logic [8:0][W-1:0] comp;
  logic signed [DW-1:0] xf, yf, zf, yu, yr;
  logic signed [DW-1:0] x_r, y_r, x_n, y_n, opx, opy, px, py, m;
  logic signed [DW+17:0] mprod;
  logic signed [AW-1:0] z_r, z_n, pz, res, yaw_a, pitch_a;
  logic zero_r, pass, load, last, accept, unused_comp;
  assign xf = DW'($signed(comp[0]));
  assign yf = DW'($signed(comp[1]));
  assign zf = DW'($signed(comp[2]));
  assign yu = DW'($signed(comp[4]));
  assign yr = DW'($signed(comp[7]));
  assign unused_comp = ^{comp[3], comp[5], comp[6], comp[8]};
  always_ff @(posedge clk_100mhz or negedge rst_in)
    if (!rst_in) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? YAW : IDLE;
      YAW:     state_n = last ? PITCH : YAW;
      PITCH:   state_n = last ? ROLL : PITCH;
      ROLL:    state_n = last ? DONE : ROLL;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    accept = state == IDLE && valid_in && ready_in;
    pass = state == YAW || state == PITCH || state == ROLL;
    load = pass && cnt == 5'd0;
    last = cnt == 5'd16;
  end
  // Pitch reuses the yaw pass magnitude, scaled by 1/K to undo CORDIC gain
  always_comb begin
    mprod = x_r * INV_K;
    m = DW'(mprod >>> FRAC);
    opx = state == YAW ? zf : state == PITCH ? m : yu;
    opy = state == YAW ? xf : state == PITCH ? -yf : -yr;
    px = !opx[DW-1] ? opx : opy[DW-1] ? -opy : opy;
    py = !opx[DW-1] ? opy : opy[DW-1] ? opx : -opx;
    pz = !opx[DW-1] ? '0 : opy[DW-1] ? -DEG90 : DEG90;
    res = zero_r ? '0 : z_r;
  end
  cordic_vectoring u_cordic (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .shift (4'(cnt - 5'd1)),
    .x_n   (x_n),
    .y_n   (y_n),
    .z_n   (z_n)
  );
  always_ff @(posedge clk_100mhz or negedge rst_in)
    if (!rst_in) begin
      cnt <= '0;
      comp <= '0;
      x_r <= '0;
      y_r <= '0;
      z_r <= '0;
      zero_r <= 1'b0;
      yaw_a <= '0;
      pitch_a <= '0;
    end else begin
      cnt <= pass && !last ? cnt + 5'd1 : 5'd0;
      if (accept)
        comp <= {clamp(z_right), clamp(y_right), clamp(x_right),
                 clamp(z_up), clamp(y_up), clamp(x_up),
                 clamp(z_forward), clamp(y_forward), clamp(x_forward)};
      if (load) begin
        x_r <= px;
        y_r <= py;
        z_r <= pz;
        zero_r <= opx == '0 && opy == '0;
      end else if (pass) begin
        x_r <= x_n;
        y_r <= y_n;
        z_r <= z_n;
      end
      if (load && state == PITCH) yaw_a <= res;
      if (load && state == ROLL) pitch_a <= res;
    end
  always_ff @(posedge clk_100mhz or negedge rst_in)
    if (!rst_in) begin
      pitch <= '0;
      roll <= '0;
      yaw <= '0;
`ifdef VIEW_ANGLES_FRAC_EN
      pitch_frac <= '0;
      roll_frac <= '0;
      yaw_frac <= '0;
`endif
      valid_out <= 1'b0;
      ready_in <= 1'b0;
    end else begin
      valid_out <= state == DONE;
      ready_in <= state_n == IDLE && state != DONE;
      if (state == DONE) begin
        pitch <= deg_int(pitch_a);
        roll <= deg_int(res);
        yaw <= deg_int(yaw_a);
`ifdef VIEW_ANGLES_FRAC_EN
        pitch_frac <= deg_frac(pitch_a);
        roll_frac <= deg_frac(res);
        yaw_frac <= deg_frac(yaw_a);
`endif
      end
    end
endmodule

// File: doc/view_angles_extract.md
VIEW_ANGLES_EXTRACT -- requirements
Module: view_angles_extract

Interface
REQ-001 SHALL provide port clk_100mhz, input, 1 bit: the single clock; all logic is rising-edge.
REQ-002 SHALL provide port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL provide port valid_in, input, 1 bit: basis-vector set present.
REQ-004 SHALL provide port ready_in, output, 1 bit: block can accept; high only in IDLE.
REQ-005 SHALL provide ports x_forward, y_forward, z_forward, x_up, y_up, z_up, x_right, y_right, z_right, each input, 32 bits signed, Q16.16 (1.0 = 65536).
REQ-006 SHALL provide ports pitch, roll, yaw, each output, 9 bits unsigned, integer degrees 0..359.
REQ-007 SHALL provide port valid_out, output, 1 bit: one-cycle pulse marking new angles.

Function
REQ-008 SHALL accept an input on a rising edge with valid_in && ready_in, registering all nine components; valid_in while ready_in is low SHALL be ignored.
REQ-009 SHALL clamp each captured component to ±131072 before use.
REQ-010 SHALL compute yaw = atan2(x_forward, z_forward).
REQ-011 SHALL compute pitch = atan2(-y_forward, M), where M = sqrt(x_forward² + z_forward²) is taken gain-compensated from the yaw pass.
REQ-012 SHALL compute roll = atan2(-y_right, y_up).
REQ-013 SHALL map each angle to [0,360) by adding 360 to negative results, round to the nearest degree, and map 360 to 0.
REQ-014 SHALL return 0 for atan2(0,0).
REQ-015 SHALL use one shared 16-iteration CORDIC vectoring datapath.
REQ-016 SHALL apply a quadrant pre-rotation (±90 deg) to the CORDIC input whenever x<0.
REQ-017 SHALL use FSM states IDLE -> YAW -> PITCH -> ROLL -> DONE -> IDLE.
REQ-018 SHALL spend exactly 17 cycles in each pass state: 1 pre-rotation cycle plus 16 iterations.
REQ-019 SHALL spend exactly 1 cycle in DONE, during which the output registers update.
REQ-020 SHALL assert valid_out on the edge ending DONE, fixed latency 52 cycles after the accepting edge.
REQ-021 SHALL raise ready_in in the cycle after valid_out; outputs hold until the next valid_out.
REQ-022 SHALL achieve accuracy of ±1 degree for unit-length inputs.

Reset
REQ-023 On reset assertion, SHALL go to IDLE immediately, asynchronously, including mid-computation, discarding any in-flight work.
REQ-024 Reset values SHALL be: pitch=0, roll=0, yaw=0, valid_out=0, ready_in=0.
REQ-025 SHALL assert ready_in on the first clock edge after rst_in deasserts.

Configuration
REQ-026 With VIEW_ANGLES_FRAC_EN defined, SHALL add outputs pitch_frac, roll_frac, yaw_frac, each 4 bits, giving 1/16-degree fractions, reset 0.
REQ-027 With VIEW_ANGLES_FRAC_EN defined, the integer outputs SHALL truncate rather than round; without the macro the _frac ports SHALL NOT exist and REQ-013 rounding applies.

Structure
REQ-028 Package view_pkg SHALL hold: Q16.16 width constants, the 16-entry CORDIC arctangent table (degrees, Q9.16), the CORDIC gain-compensation constant 1/K, and the FSM state enum.
REQ-029 SHALL instantiate one sub-module, cordic_vectoring, implementing one iteration: shift, add/sub, angle accumulate.

Verification
REQ-030 Identity (forward 0,0,65536; up 0,65536,0; right 65536,0,0) -> pitch=0, roll=0, yaw=0; valid_out exactly 52 cycles after accept.
REQ-031 Forward 0,-65536,0; up 0,0,65536; right 65536,0,0 -> pitch=90, yaw=0, roll=0.
REQ-032 Forward -65536,0,0; up 0,65536,0; right 0,0,65536 -> yaw=270, pitch=0, roll=0.
REQ-033 Forward 0,0,65536; up -46341,46341,0; right 46341,46341,0 -> roll=315, pitch=0, yaw=0.
REQ-034 Second valid_in pulse 10 cycles after accept -> ignored: exactly one valid_out, ready_in low until after DONE.
REQ-035 rst_in low at cycle 30 of a computation -> outputs 0 and ready_in 0 immediately, no valid_out; a new accept after release -> correct result at +52 cycles.
